// File: rtl/d_sram_bridge_pkg.sv
// Shared definitions for the data-side SRAM bridge: FSM encoding, bus size codes,
// kernel segment tags and the store-mask decode helpers.
package d_sram_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [2:0] KSEG0 = 3'b100;
  localparam logic [2:0] KSEG1 = 3'b101;

  // Single-lane masks are byte accesses, paired lanes are halfwords; reads and
  // any irregular mask fall back to a full word.
  function automatic logic [1:0] size_of(input logic [3:0] mask);
    case (mask)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return SZ_BYTE;
      4'b0011, 4'b1100:                   return SZ_HALF;
      default:                            return SZ_WORD;
    endcase
  endfunction

  function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic [1:0] size);
    case (size)
      SZ_BYTE: return addr;
      SZ_HALF: return {addr[31:1], 1'b0};
      default: return {addr[31:2], 2'b00};
    endcase
  endfunction

endpackage

// File: rtl/d_sram_bridge_if.sv
// SRAM-style data bus between the bridge (master) and the memory system (slave).
// Handshake: data_req is held while the address is offered; the request is taken on
// the cycle data_addr_ok=1, and data_data_ok=1 marks the cycle the data phase ends.
interface d_sram_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/d_sram_bridge_addr_map.sv
// Virtual-to-physical translation: kseg0/kseg1 fold onto the low 512 MB,
// everything else passes through. Shared with the instruction-side bridge.
module addr_map
  import d_sram_bridge_pkg::*;
(
  input  logic [31:0] vaddr,
  output logic [31:0] paddr
);

  always_comb begin
    paddr = vaddr;
    if (vaddr[31:29] == KSEG0 || vaddr[31:29] == KSEG1) begin
      paddr = {3'b000, vaddr[28:0]};
    end
  end

endmodule

// File: rtl/d_sram_bridge.sv
// Data-side bridge from the M-stage memory request to an SRAM-style bus.
// One access at a time: IDLE -> ADDR -> (DATA) -> HOLD, stalling the core until HOLD.
module d_sram_bridge
  import d_sram_bridge_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                memenM,
  input  logic [3:0]          memwriteM,
  input  logic [31:0]         aluoutM,
  input  logic [31:0]         writedataM,
  output logic [31:0]         readdataM,
  output logic                d_stall,
  output state_t              fsm_state,
  d_sram_bridge_if.master     bus
);

  state_t      state, state_n;
  logic        latch, capture;
  logic [1:0]  req_size;
  logic [31:0] aligned_addr, phys_addr;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;

  assign req_size     = size_of(memwriteM);
  assign aligned_addr = align_addr(aluoutM, req_size);

  addr_map u_addr_map (
    .vaddr (aligned_addr),
    .paddr (phys_addr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Bus handshakes only count in the states that expect them; strays elsewhere fall through.
  always_comb begin
    state_n = state;
    latch   = 1'b0;
    capture = 1'b0;
    case (state)
      S_IDLE: begin
        if (memenM) begin
          state_n = S_ADDR;
          latch   = 1'b1;
        end
      end
      S_ADDR: begin
        if (bus.data_addr_ok) begin
          state_n = bus.data_data_ok ? S_HOLD : S_DATA;
          capture = bus.data_data_ok & ~wr_q;
        end
      end
      S_DATA: begin
        if (bus.data_data_ok) begin
          state_n = S_HOLD;
          capture = ~wr_q;
        end
      end
      S_HOLD:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Request fields are frozen at acceptance so core-side changes during the stall are harmless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (latch) begin
      wr_q    <= |memwriteM;
      size_q  <= req_size;
      addr_q  <= phys_addr;
      wdata_q <= writedataM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         readdataM <= '0;
    else if (capture) readdataM <= bus.data_rdata;
  end

  assign d_stall        = memenM && (state != S_HOLD);
  assign fsm_state      = state;
  assign bus.data_req   = (state == S_ADDR);
  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_q;

endmodule

// File: doc/d_sram_bridge.md
D_SRAM_BRIDGE -- requirements
Module: d_sram_bridge

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clock and reset ports SHALL be named clk and rst as elsewhere in the codebase.
REQ-002 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-004 memenM  in  1  core data-access request, M stage.
REQ-005 memwriteM  in  4  byte write enables; 0000 = read.
REQ-006 aluoutM  in  32  virtual byte address.
REQ-007 writedataM  in  32  store data, already lane-aligned.
REQ-008 readdataM  out  32  load data returned to core.
REQ-009 d_stall  out  1  freeze request to the pipeline.
REQ-010 data_req, data_wr  out  1 each  bus request / write flag.
REQ-011 data_size  out  2  0 = byte, 1 = half, 2 = word.
REQ-012 data_addr, data_wdata  out  32 each  physical address / store data.
REQ-013 data_addr_ok, data_data_ok  in  1 each  address accepted / data phase done.
REQ-014 data_rdata  in  32  bus read data.

Function
REQ-015 FSM states SHALL be IDLE, ADDR, DATA, HOLD.
REQ-016 IDLE: when memenM=1, the block SHALL latch wr, size, address and wdata into bus registers and go to ADDR; when memenM=0, it SHALL stay in IDLE.
REQ-017 ADDR: data_req SHALL be 1; on addr_ok=1 the FSM SHALL go to DATA, or to HOLD if data_ok=1 in the same cycle.
REQ-018 DATA: data_req SHALL be 0; on data_ok=1 the FSM SHALL go to HOLD.
REQ-019 On every data_ok=1 for a read, data_rdata SHALL be captured into readdataM.
REQ-020 HOLD: the FSM SHALL go to IDLE unconditionally; HOLD lasts exactly one cycle.
REQ-021 d_stall SHALL be combinational: 1 when memenM=1 and state is not HOLD, else 0.
- IDLE with memenM=1 therefore stalls in the same cycle.
- Minimum access latency: 3 cycles (IDLE, ADDR, HOLD).
REQ-022 data_wr SHALL be 1 when memwriteM is nonzero.
REQ-023 Size and address by memwriteM:
- 0001/0010/0100/1000 -> size 0, exact address.
- 0011/1100 -> size 1, address with bit 0 cleared.
- 1111, 0000 (read) and all other masks -> size 2, address with bits 1:0 cleared.
REQ-024 Physical address mapping:
- aluoutM[31:29] = 100 or 101 -> {000, aluoutM[28:0]}.
- Otherwise the address passes unchanged.
REQ-025 Bus outputs SHALL hold stable from ADDR entry until HOLD ends.
REQ-026 data_ok=1 while in IDLE SHALL be ignored.
REQ-027 addr_ok=1 outside ADDR SHALL be ignored.
REQ-028 Changes on the core inputs while stalled SHALL NOT affect an access already in flight.
REQ-029 readdataM SHALL keep its last value until the next read completes.

Reset
REQ-030 rst=0 SHALL force, asynchronously:
- state = IDLE;
- data_req = 0, data_wr = 0, data_size = 0, data_addr = 0, data_wdata = 0;
- readdataM = 0.
REQ-031 Reset asserted mid-access SHALL abandon the transaction; no completion SHALL be reported after reset release.

Structure
REQ-032 A shared package SHALL hold:
- the state encoding;
- size codes (SZ_BYTE, SZ_HALF, SZ_WORD);
- kseg0/kseg1 segment constants.
REQ-033 Address mapping SHALL be one combinational sub-module, addr_map, reusable by the instruction-side bridge.
REQ-034 Total RTL SHALL be 120-400 lines.

Verification
REQ-035 Word read, addr 0x8000_0010, addr_ok in cycle 2, data_ok in cycle 4 with rdata 0xDEAD_BEEF -> data_addr 0x0000_0010, size 2, wr 0, d_stall high for 4 cycles, readdataM 0xDEAD_BEEF in HOLD.
REQ-036 Byte store, memwriteM 0100, addr 0xA000_0006, addr_ok and data_ok in the same cycle -> data_addr 0x0000_0006, size 0, wr 1, DATA state skipped, stall 2 cycles.
REQ-037 Half store, mask 1100, addr 0x1FC0_0003 -> data_addr 0x1FC0_0002, size 1.
REQ-038 Back-to-back accesses, memenM held 1 across HOLD -> exactly one idle-free restart, each access issued once, no duplicate data_req.
REQ-039 rst pulsed low while in DATA -> immediate IDLE, all outputs 0; a stray data_ok after release is ignored and readdataM stays 0.
